// File: rtl/apu_mem_arbiter_pkg.sv
// Shared types and sizes for the APU DDR3 read arbiter (package apu_pkg).
package apu_pkg;
  localparam int APU_MEM_ADDR_W = 29;
  localparam int APU_MEM_DATA_W = 64;
  localparam int APU_N_VOICES   = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

  function automatic int ptr_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/apu_mem_arbiter_if.sv
// Fetcher-side and DDR3-side signals of the APU read arbiter.
interface apu_mem_arbiter_if #(
  parameter int N_REQ  = apu_pkg::APU_N_VOICES,
  parameter int ADDR_W = apu_pkg::APU_MEM_ADDR_W,
  parameter int DATA_W = apu_pkg::APU_MEM_DATA_W
);
  logic [N_REQ-1:0]             req_read_en;
  logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]             req_ack;
  logic [DATA_W-1:0]            req_data;
  logic [ADDR_W-1:0]            mem_addr;
  logic                         mem_read_en;
  logic [DATA_W-1:0]            mem_data;
  logic                         mem_ack;
  logic                         timeout_err;

  modport slave (
    input  req_read_en, req_addr, mem_data, mem_ack,
    output req_ack, req_data, mem_addr, mem_read_en, timeout_err
  );
  modport master (
    output req_read_en, req_addr, mem_data, mem_ack,
    input  req_ack, req_data, mem_addr, mem_read_en, timeout_err
  );
endinterface

// File: rtl/apu_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index at or after rr_ptr, wrapping.
module apu_rr_pick import apu_pkg::*; #(
  parameter int N_REQ = APU_N_VOICES,
  parameter int PTR_W = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] winner,
  output logic             any_pending
);
  int idx;

  always_comb begin
    winner      = '0;
    any_pending = 1'b0;
    idx         = 0;
    // scan farthest-first so the nearest pending index is the last to write
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (pending[PTR_W'(idx)]) begin
        winner      = PTR_W'(idx);
        any_pending = 1'b1;
      end
    end
  end
endmodule

// File: rtl/apu_mem_arbiter.sv
// Round-robin arbiter sharing the APU's single DDR3 read port among sample fetchers.
// Optional abort of stuck reads: define APU_MEM_ARB_TIMEOUT_EN.
module apu_mem_arbiter import apu_pkg::*; #(
  parameter int N_REQ   = APU_N_VOICES,
  parameter int ADDR_W  = APU_MEM_ADDR_W,
  parameter int DATA_W  = APU_MEM_DATA_W,
  parameter int TIMEOUT = 255
) (
  input logic              clock,
  input logic              reset,
  apu_mem_arbiter_if.slave bus
);
  localparam int PTR_W = ptr_w(N_REQ);

  arb_state_t                   state;
  logic [N_REQ-1:0]             pending;
  logic [N_REQ-1:0][ADDR_W-1:0] addr_q;
  logic [PTR_W-1:0]             rr_ptr, grant, winner;
  logic                         any_pending;
  logic [N_REQ-1:0]             req_ack_q;
  logic [DATA_W-1:0]            req_data_q;
  logic [ADDR_W-1:0]            mem_addr_q;
  logic                         mem_read_en_q;
`ifdef APU_MEM_ARB_TIMEOUT_EN
  logic [7:0]                   wait_cnt;
  logic                         timeout_err_q;
`endif

  apu_rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .pending     (pending),
    .rr_ptr      (rr_ptr),
    .winner      (winner),
    .any_pending (any_pending)
  );

  // a pulse on an already-pending requester is dropped; its first address stands
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
      addr_q  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (state == DONE && grant == PTR_W'(i)) begin
          pending[i] <= 1'b0;
        end else if (bus.req_read_en[i] && !pending[i]) begin
          pending[i] <= 1'b1;
          addr_q[i]  <= bus.req_addr[i];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      req_ack_q     <= '0;
      req_data_q    <= '0;
      mem_addr_q    <= '0;
      mem_read_en_q <= 1'b0;
`ifdef APU_MEM_ARB_TIMEOUT_EN
      wait_cnt      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      req_ack_q     <= '0;
      mem_read_en_q <= 1'b0;
      case (state)
        IDLE: if (any_pending) begin
          grant         <= winner;
          rr_ptr        <= (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + PTR_W'(1);
          mem_addr_q    <= addr_q[winner];
          mem_read_en_q <= 1'b1;
          state         <= ISSUE;
        end
        ISSUE, WAIT: begin
          if (bus.mem_ack) begin
            req_ack_q  <= N_REQ'(1) << grant;
            req_data_q <= bus.mem_data;
            state      <= DONE;
          end else begin
`ifdef APU_MEM_ARB_TIMEOUT_EN
            if (state == ISSUE) begin
              wait_cnt <= '0;
              state    <= WAIT;
            end else if (wait_cnt + 8'd1 == 8'(TIMEOUT)) begin
              req_ack_q     <= N_REQ'(1) << grant;
              req_data_q    <= '0;
              timeout_err_q <= 1'b1;
              state         <= DONE;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
`else
            state <= WAIT;
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ack     = req_ack_q;
  assign bus.req_data    = req_data_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_read_en = mem_read_en_q;
`ifdef APU_MEM_ARB_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_q;
`else
  // no abort path in this build, so the flag is constant low
  assign bus.timeout_err = (TIMEOUT < 0);
`endif

  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N_REQ; i++)
        assert (!(bus.req_read_en[i] && pending[i]))
          else $warning("apu_mem_arbiter: duplicate read pulse on pending requester %0d", i);
    end
  end
endmodule

// File: tb/tb_apu_mem_arbiter.sv
// Bench for apu_mem_arbiter: table bursts, directed corner sequences, random traffic vs a queue model.
module tb_apu_mem_arbiter;
  import apu_pkg::*;
  localparam int N  = 4;
  localparam int AW = 29;
  localparam int DW = 64;
  localparam int TO = 255;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  apu_mem_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  apu_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // reference model state
  logic [N-1:0]  mp;
  logic [AW-1:0] maddr [N];
  int            rr, cur, age, clr_idx;
  bit            outst, exp_ack, clr_next, terr;
  logic [DW-1:0] exp_data;
  int            n_reads, n_acks, n_caps, atick;
  logic [AW-1:0] last_read_addr;
  int            glog[$];
  int            rtick[$];

  // DDR3 responder: -1 never answers, -2 random latency
  int            ddr_lat = 0;
  bit            ddr_busy, force_ack;
  int            ddr_cnt;
  logic [AW-1:0] ddr_addr;

  typedef struct {
    logic [N-1:0]  mask;
    int            lat;
    int            n;
    logic [15:0]   ord;
    logic [AW-1:0] base;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [DW-1:0] ddr_word(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hBEEF, 3'b000, a, 16'hC0DE};
  endfunction

  function automatic int pick(input logic [N-1:0] p, input int r);
    for (int k = 0; k < N; k++)
      if (p[(r + k) % N]) return (r + k) % N;
    return -1;
  endfunction

  task automatic model_clear();
    mp = '0; rr = 0; cur = 0; age = 0; outst = 0; exp_ack = 0;
    clr_next = 0; clr_idx = 0; terr = 0; ddr_busy = 0; force_ack = 0;
  endtask

  task automatic tick();
    logic [N-1:0]         sent_en, fresh;
    logic [N-1:0][AW-1:0] sent_addr;
    bit                   acked;
    int                   w;
    sent_en   = bus.req_read_en;
    sent_addr = bus.req_addr;
    @(posedge clock); #1;
    cyc++;
    acked = 1'b0;
    if (reset) begin
      model_clear();
      bus.mem_ack = 1'b0;
    end else begin
      if (bus.mem_read_en) begin
        w = pick(mp, rr);
        chk("read_has_pending", 64'(w >= 0), 64'd1);
        chk("single_outstanding", 64'(outst), 64'd0);
        if (w >= 0) begin
          chk("mem_addr", 64'(bus.mem_addr), 64'(maddr[w]));
          cur = w;
          rr  = (w + 1) % N;
        end
        outst = 1; age = 0; n_reads++;
        last_read_addr = bus.mem_addr;
        rtick.push_back(cyc);
      end
      if (exp_ack || bus.req_ack != '0) begin
        chk("req_ack", 64'(bus.req_ack), exp_ack ? (64'd1 << cur) : 64'd0);
        if (exp_ack) begin
          chk("req_data", 64'(bus.req_data), 64'(exp_data));
          glog.push_back(cur);
          n_acks++; atick = cyc; acked = 1; outst = 0; exp_ack = 0;
        end
      end
      fresh = sent_en & ~mp;
      if (clr_next) mp[clr_idx] = 1'b0;
      for (int i = 0; i < N; i++)
        if (fresh[i]) begin mp[i] = 1'b1; maddr[i] = sent_addr[i]; n_caps++; end
      clr_next = acked;
      clr_idx  = cur;
      bus.mem_ack = 1'b0;
      if (bus.mem_read_en) begin
        ddr_busy = 1; ddr_addr = bus.mem_addr;
        ddr_cnt  = (ddr_lat == -2) ? int'($urandom_range(0, 6)) : ddr_lat;
      end
      if (ddr_busy && ddr_cnt == 0) begin
        bus.mem_ack = 1'b1; bus.mem_data = ddr_word(ddr_addr); ddr_busy = 0;
      end else if (ddr_busy && ddr_cnt > 0) begin
        ddr_cnt--;
      end
      if (force_ack) begin
        bus.mem_ack = 1'b1; bus.mem_data = {$urandom, $urandom}; force_ack = 0;
      end
      if (outst && !exp_ack) begin
        if (bus.mem_ack) begin
          exp_ack = 1; exp_data = bus.mem_data;
        end
`ifdef APU_MEM_ARB_TIMEOUT_EN
        else if (age == TO) begin
          exp_ack = 1; exp_data = '0; terr = 1;
        end
`endif
        age++;
      end
    end
    bus.req_read_en = '0;
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    for (int k = 0; k < budget && n_acks < target; k++) tick();
    chk(name, 64'(n_acks), 64'(target));
  endtask

  task automatic run_burst(input logic [N-1:0] mask, input int lat, input logic [AW-1:0] base,
                           input int n_exp, output int t0);
    glog.delete();
    rtick.delete();
    ddr_lat = lat;
    for (int i = 0; i < N; i++)
      if (mask[i]) begin bus.req_read_en[i] = 1'b1; bus.req_addr[i] = base + AW'(i); end
    t0 = cyc;
    for (int k = 0; k < 200 && glog.size() < n_exp; k++) tick();
    chk("burst_done", 64'(glog.size()), 64'(n_exp));
  endtask

  initial begin
    int t0, base_acks, base_reads;
    bus.req_read_en = '0;
    bus.req_addr    = '0;
    bus.mem_data    = '0;
    bus.mem_ack     = 1'b0;
    model_clear();
    n_reads = 0; n_acks = 0; n_caps = 0; atick = 0; last_read_addr = '0;

    vecs[0] = '{4'b0001, 0, 1, 16'h0000, 29'h100};
    vecs[1] = '{4'b1000, 2, 1, 16'h0003, 29'h180};
    vecs[2] = '{4'b1111, 5, 4, 16'h3210, 29'h010};
    vecs[3] = '{4'b0110, 0, 2, 16'h0021, 29'h1C0};
    vecs[4] = '{4'b0111, 1, 3, 16'h0210, 29'h200};
    vecs[5] = '{4'b1010, 4, 2, 16'h0013, 29'h240};
    vecs[6] = '{4'b0101, 0, 2, 16'h0002, 29'h280};
    vecs[7] = '{4'b1101, 3, 3, 16'h0032, 29'h2C0};

    #2 reset = 1'b1;
    tick(); tick();
    chk("rst_req_ack", 64'(bus.req_ack), 64'd0);
    chk("rst_req_data", 64'(bus.req_data), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_read_en", 64'(bus.mem_read_en), 64'd0);
    chk("rst_timeout_err", 64'(bus.timeout_err), 64'd0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 8; v++) begin
      run_burst(vecs[v].mask, vecs[v].lat, vecs[v].base, vecs[v].n, t0);
      chk($sformatf("v%0d_issue_lat", v), 64'(rtick.size() > 0 ? rtick[0] - t0 : -1), 64'd2);
      for (int k = 0; k < vecs[v].n; k++)
        chk($sformatf("v%0d_order%0d", v, k), 64'(glog.size() > k ? glog[k] : -1),
            64'((vecs[v].ord >> (4 * k)) & 16'hF));
      tick(); tick();
      if (glog.size() > 0)
        chk($sformatf("v%0d_data_hold", v), 64'(bus.req_data),
            64'(ddr_word(vecs[v].base + AW'(glog[glog.size() - 1]))));
    end

    // fairness: move rr_ptr to 2, then 0 and 3 contend, then 3 re-requests
    run_burst(4'b0010, 1, 29'h300, 1, t0);
    glog.delete();
    ddr_lat = 3;
    bus.req_read_en[0] = 1'b1; bus.req_addr[0] = 29'h3A0;
    bus.req_read_en[3] = 1'b1; bus.req_addr[3] = 29'h3A3;
    for (int k = 0; k < 100 && glog.size() < 1; k++) tick();
    chk("fair_first", 64'(glog.size() > 0 ? glog[0] : -1), 64'd3);
    tick();
    bus.req_read_en[3] = 1'b1; bus.req_addr[3] = 29'h333;
    for (int k = 0; k < 100 && glog.size() < 3; k++) tick();
    chk("fair_second", 64'(glog.size() > 1 ? glog[1] : -1), 64'd0);
    chk("fair_third", 64'(glog.size() > 2 ? glog[2] : -1), 64'd3);
    chk("fair_readdr", 64'(last_read_addr), 64'h333);
    tick(); tick();

    // duplicate pulse while pending
    base_reads = n_reads;
    bus.req_read_en[2] = 1'b1; bus.req_addr[2] = 29'h444;
    tick();
    bus.req_read_en[2] = 1'b1; bus.req_addr[2] = 29'h555;
    wait_acks(n_acks + 1, 100, "dup_done");
    tick(); tick(); tick();
    chk("dup_one_read", 64'(n_reads - base_reads), 64'd1);
    chk("dup_addr", 64'(last_read_addr), 64'h444);

    // reset in WAIT, then a late DDR3 ack
    ddr_lat = -1;
    base_reads = n_reads;
    bus.req_read_en[1] = 1'b1; bus.req_addr[1] = 29'h666;
    for (int k = 0; k < 20 && n_reads == base_reads; k++) tick();
    chk("rst_mid_issued", 64'(n_reads - base_reads), 64'd1);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_req_data", 64'(bus.req_data), 64'd0);
    chk("rst_mid_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mid_read_en", 64'(bus.mem_read_en), 64'd0);
    reset = 1'b0;
    tick();
    base_acks = n_acks; base_reads = n_reads;
    force_ack = 1;
    for (int k = 0; k < 6; k++) tick();
    chk("rst_stray_no_ack", 64'(n_acks - base_acks), 64'd0);
    chk("rst_stray_no_read", 64'(n_reads - base_reads), 64'd0);
    chk("rst_stray_req_ack", 64'(bus.req_ack), 64'd0);

`ifdef APU_MEM_ARB_TIMEOUT_EN
    ddr_lat = -1;
    base_acks = n_acks;
    rtick.delete();
    bus.req_read_en[0] = 1'b1; bus.req_addr[0] = 29'h777;
    wait_acks(base_acks + 1, 400, "to_acked");
    chk("to_wait_cycles", 64'(rtick.size() > 0 ? atick - rtick[0] : -1), 64'(TO + 1));
    chk("to_req_data", 64'(bus.req_data), 64'd0);
    chk("to_err_set", 64'(bus.timeout_err), 64'd1);
    tick();
    force_ack = 1;
    tick(); tick(); tick();
    chk("to_late_ignored", 64'(n_acks - base_acks), 64'd1);
    run_burst(4'b0100, 2, 29'h7A0, 1, t0);
    chk("to_next_served", 64'(glog.size() > 0 ? glog[0] : -1), 64'd2);
    chk("to_err_sticky", 64'(bus.timeout_err), 64'd1);
`endif

    // random traffic against the model
    ddr_lat = -2;
    base_acks = n_acks;
    n_caps = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (!mp[i] && $urandom_range(0, 7) == 0) begin
          bus.req_read_en[i] = 1'b1;
          bus.req_addr[i]    = AW'($urandom);
        end
      tick();
    end
    for (int k = 0; k < 300 && (mp != '0 || outst); k++) tick();
    chk("rand_drained", 64'(mp), 64'd0);
    chk("rand_all_served", 64'(n_acks - base_acks), 64'(n_caps));
    chk("timeout_err_final", 64'(bus.timeout_err), 64'(terr));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
